// File: rtl/decode_dec_irq.sv
// rtl/decode_dec_irq.sv - decode-stage asynchronous exception request (decrementer / external)
// Optional feature macro: DEC_IRQ_EXT_SYNC_EN (two-flop synchronizer on ext_irq)
module decode_dec_irq #(
  parameter logic [11:0] DEC_VECTOR = 12'h900,
  parameter logic [11:0] EXT_VECTOR = 12'h500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_trigger,
  input  logic        write_dec,
  input  logic [31:0] write_val,
  input  logic        ext_irq,
  input  logic        msr_ee,
  input  logic        irq_ack,
  output logic        irq_req,
  output logic [11:0] irq_vector,
  output logic        dec_pending
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_TAKEN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_dec_prev;
  logic        r_dec_pending;
  logic        w_dec_pending_nxt;
  logic        r_irq_req;
  logic [11:0] r_irq_vector;
  logic [11:0] w_irq_vector_nxt;
  logic        r_src_ext;
  logic        w_src_ext_nxt;
  logic        w_ext_lvl;
  logic        w_dec_edge;
  logic        w_mtdec_clr;
  logic        w_ack_take;
  logic        w_ack_dec;
  logic        w_src_live;
  logic        w_unused_wval;

  // Only the sign bit of the mtdec data matters here.
  assign w_unused_wval = ^write_val[30:0];

`ifdef DEC_IRQ_EXT_SYNC_EN
  logic r_ext_s1;
  logic r_ext_s2;

  // Two-flop synchronizer for the external interrupt line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
    end else begin
      r_ext_s1 <= ext_irq;
      r_ext_s2 <= r_ext_s1;
    end
  end

  assign w_ext_lvl = r_ext_s2;
`else
  assign w_ext_lvl = ext_irq;
`endif

  assign w_dec_edge  = dec_trigger & ~r_dec_prev;
  assign w_mtdec_clr = write_dec & ~write_val[31];
  assign w_ack_take  = (r_state == S_REQ) & irq_ack;
  assign w_ack_dec   = w_ack_take & ~r_src_ext;

  // Pending latch: an mtdec clear beats a fresh edge, a fresh edge beats the ack clear.
  always_comb begin
    w_dec_pending_nxt = r_dec_pending;
    if (w_mtdec_clr) begin
      w_dec_pending_nxt = 1'b0;
    end else if (w_dec_edge) begin
      w_dec_pending_nxt = 1'b1;
    end else if (w_ack_dec) begin
      w_dec_pending_nxt = 1'b0;
    end
  end

  // The latched source is still live when its level (ext) or next pending value (dec) holds.
  assign w_src_live = r_src_ext ? w_ext_lvl : w_dec_pending_nxt;

  // Request FSM next-state and vector latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_irq_vector_nxt = r_irq_vector;
    w_src_ext_nxt    = r_src_ext;
    case (r_state)
      S_IDLE: begin
        if (msr_ee && (w_ext_lvl || r_dec_pending)) begin
          w_state_nxt      = S_REQ;
          w_src_ext_nxt    = w_ext_lvl;
          w_irq_vector_nxt = w_ext_lvl ? EXT_VECTOR : DEC_VECTOR;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          w_state_nxt = S_TAKEN;
        end else if (!msr_ee || !w_src_live) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TAKEN: begin
        // Hold off until exception entry has cleared EE, so one event is taken once.
        if (!msr_ee) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, edge detector, pending latch and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_dec_prev    <= 1'b0;
      r_dec_pending <= 1'b0;
      r_irq_req     <= 1'b0;
      r_irq_vector  <= 12'h000;
      r_src_ext     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dec_prev    <= dec_trigger;
      r_dec_pending <= w_dec_pending_nxt;
      r_irq_req     <= (w_state_nxt == S_REQ);
      r_irq_vector  <= w_irq_vector_nxt;
      r_src_ext     <= w_src_ext_nxt;
    end
  end

  assign irq_req     = r_irq_req;
  assign irq_vector  = r_irq_vector;
  assign dec_pending = r_dec_pending;

endmodule

// File: tb/tb_decode_dec_irq.sv
// tb/tb_decode_dec_irq.sv - self-checking bench for decode_dec_irq
module tb_decode_dec_irq;

  localparam logic [11:0] DEC_V = 12'h900;
  localparam logic [11:0] EXT_V = 12'h500;
`ifdef DEC_IRQ_EXT_SYNC_EN
  localparam int EXT_LAT = 3;
`else
  localparam int EXT_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_trigger = 1'b0;
  logic        write_dec = 1'b0;
  logic [31:0] write_val = 32'h0;
  logic        ext_irq = 1'b0;
  logic        msr_ee = 1'b0;
  logic        irq_ack = 1'b0;
  logic        irq_req;
  logic [11:0] irq_vector;
  logic        dec_pending;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic        m_prev = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_req = 1'b0;
  logic        m_hold = 1'b0;
  logic [11:0] m_vec = 12'h0;
  logic        m_s1 = 1'b0;
  logic        m_s2 = 1'b0;

  decode_dec_irq #(.DEC_VECTOR(DEC_V), .EXT_VECTOR(EXT_V)) dut (
    .clk(clk),
    .reset(reset),
    .dec_trigger(dec_trigger),
    .write_dec(write_dec),
    .write_val(write_val),
    .ext_irq(ext_irq),
    .msr_ee(msr_ee),
    .irq_ack(irq_ack),
    .irq_req(irq_req),
    .irq_vector(irq_vector),
    .dec_pending(dec_pending)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the inputs present now, advance, compare.
  task automatic cyc();
    logic        ext_use, edge_seen, mt_clr, acc, np, nreq, nhold;
    logic [11:0] nvec;
`ifdef DEC_IRQ_EXT_SYNC_EN
    ext_use = m_s2;
`else
    ext_use = ext_irq;
`endif
    edge_seen = dec_trigger && !m_prev;
    mt_clr    = write_dec && !write_val[31];
    acc       = m_req && irq_ack;
    if (mt_clr)                      np = 1'b0;
    else if (edge_seen)              np = 1'b1;
    else if (acc && m_vec == DEC_V)  np = 1'b0;
    else                             np = m_pend;
    nreq = m_req; nhold = m_hold; nvec = m_vec;
    if (m_req) begin
      if (acc) begin
        nreq = 1'b0; nhold = 1'b1;
      end else if (!msr_ee || !((m_vec == EXT_V) ? ext_use : np)) begin
        nreq = 1'b0;
      end
    end else if (m_hold) begin
      if (!msr_ee) nhold = 1'b0;
    end else if (msr_ee && (ext_use || m_pend)) begin
      nreq = 1'b1;
      nvec = ext_use ? EXT_V : DEC_V;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_prev = 0; m_pend = 0; m_req = 0; m_hold = 0; m_vec = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      m_s2 = m_s1; m_s1 = ext_irq;
      m_prev = dec_trigger; m_pend = np; m_req = nreq; m_hold = nhold; m_vec = nvec;
    end
    chk("model_req", 32'(irq_req), 32'(m_req));
    chk("model_pend", 32'(dec_pending), 32'(m_pend));
    chk("model_vec", 32'(irq_vector), 32'(m_vec));
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!irq_req && k < 10) begin
      cyc();
      k++;
    end
    chk(tag, 32'(irq_req), 32'd1);
  endtask

  initial begin
    // reset
    #1;
    cyc(); cyc();
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_vec", 32'(irq_vector), 32'd0);
    chk("rst_pend", 32'(dec_pending), 32'd0);
    reset = 1'b0;
    msr_ee = 1'b1;
    cyc();

    // decrementer edge -> pending -> request -> ack
    dec_trigger = 1'b1;
    cyc();
    chk("dec_pend_n1", 32'(dec_pending), 32'd1);
    chk("dec_req_n1", 32'(irq_req), 32'd0);
    cyc();
    chk("dec_req_n2", 32'(irq_req), 32'd1);
    chk("dec_vec_n2", 32'(irq_vector), 32'(DEC_V));
    cyc(); cyc();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    chk("ack_req", 32'(irq_req), 32'd0);
    chk("ack_pend", 32'(dec_pending), 32'd0);
    msr_ee = 1'b0; cyc();
    msr_ee = 1'b1; dec_trigger = 1'b0; cyc();

    // external beats decrementer
    ext_irq = 1'b1;
    repeat (EXT_LAT - 1) cyc();
    dec_trigger = 1'b1;
    wait_req("ext_req1");
    chk("ext_vec1", 32'(irq_vector), 32'(EXT_V));
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    msr_ee = 1'b0; cyc();
    msr_ee = 1'b1;
    wait_req("ext_req2");
    chk("ext_vec2", 32'(irq_vector), 32'(EXT_V));
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    ext_irq = 1'b0; msr_ee = 1'b0;
    repeat (3) cyc();
    msr_ee = 1'b1;
    wait_req("dec_after_ext");
    chk("dec_after_ext_vec", 32'(irq_vector), 32'(DEC_V));
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    chk("dec_after_ext_clr", 32'(dec_pending), 32'd0);
    msr_ee = 1'b0; cyc();
    msr_ee = 1'b1; dec_trigger = 1'b0; cyc();

    // edge with EE off: held, requested once EE returns
    msr_ee = 1'b0; dec_trigger = 1'b1;
    cyc();
    chk("ee0_pend", 32'(dec_pending), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("ee0_noreq", 32'(irq_req), 32'd0);
    end
    msr_ee = 1'b1;
    cyc();
    chk("ee1_req", 32'(irq_req), 32'd1);
    chk("ee1_vec", 32'(irq_vector), 32'(DEC_V));

    // mtdec clear while requesting withdraws the request
    write_dec = 1'b1; write_val = 32'h0000_1000;
    cyc();
    write_dec = 1'b0;
    chk("mt_wd_req", 32'(irq_req), 32'd0);
    chk("mt_wd_pend", 32'(dec_pending), 32'd0);
    dec_trigger = 1'b0; cyc();
    msr_ee = 1'b0; dec_trigger = 1'b1; cyc();
    write_dec = 1'b1; write_val = 32'h8000_0000;
    cyc();
    chk("mt_msb1_keep", 32'(dec_pending), 32'd1);
    write_val = 32'h0000_1000;
    cyc();
    write_dec = 1'b0;
    chk("mt_clr", 32'(dec_pending), 32'd0);

    // ack + EE clear + new edge in the same cycle
    dec_trigger = 1'b0; cyc();
    msr_ee = 1'b1; dec_trigger = 1'b1; cyc();
    cyc();
    chk("race_req", 32'(irq_req), 32'd1);
    dec_trigger = 1'b0; cyc();
    dec_trigger = 1'b1; irq_ack = 1'b1; msr_ee = 1'b0;
    cyc();
    irq_ack = 1'b0;
    chk("race_req0", 32'(irq_req), 32'd0);
    chk("race_pend", 32'(dec_pending), 32'd1);
    cyc();
    chk("race_idle", 32'(irq_req), 32'd0);
    msr_ee = 1'b1;
    cyc();
    chk("race_rereq", 32'(irq_req), 32'd1);
    chk("race_vec", 32'(irq_vector), 32'(DEC_V));

    // reset mid-handshake, trigger still high across reset
    reset = 1'b1; cyc();
    chk("mid_rst_req", 32'(irq_req), 32'd0);
    chk("mid_rst_vec", 32'(irq_vector), 32'd0);
    chk("mid_rst_pend", 32'(dec_pending), 32'd0);
    reset = 1'b0; msr_ee = 1'b0;
    cyc();
    chk("post_rst_pend", 32'(dec_pending), 32'd1);
    write_dec = 1'b1; write_val = 32'h0; cyc();
    write_dec = 1'b0; dec_trigger = 1'b0;
    reset = 1'b1; cyc();
    reset = 1'b0; ext_irq = 1'b1; msr_ee = 1'b1;
    for (int i = 0; i < EXT_LAT - 1; i++) begin
      cyc();
      chk("ext_lat_low", 32'(irq_req), 32'd0);
    end
    cyc();
    chk("ext_lat_req", 32'(irq_req), 32'd1);
    chk("ext_lat_vec", 32'(irq_vector), 32'(EXT_V));
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    ext_irq = 1'b0; msr_ee = 1'b0;
    repeat (3) cyc();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      msr_ee    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0)  dec_trigger = ~dec_trigger;
      if ($urandom_range(0, 15) == 0) ext_irq = ~ext_irq;
      write_dec = ($urandom_range(0, 19) == 0);
      write_val = $urandom;
      irq_ack   = ($urandom_range(0, 2) == 0);
      cyc();
    end
    reset = 1'b0; irq_ack = 1'b0; write_dec = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
